// File: rtl/fractal_fifo_pkg.sv
// Word format shared by solver_result_fifo_writer and hps_fifo_decoder:
// [31:29] type tag, [28:0] payload.
package fractal_fifo_pkg;

  localparam int unsigned WORD_BITS     = 32;
  localparam int unsigned TYPE_BITS     = 3;
  localparam int unsigned PAYLOAD_BITS  = WORD_BITS - TYPE_BITS;
  localparam int unsigned TYPE_LSB      = PAYLOAD_BITS;
  localparam int unsigned PAYLOAD_LSB   = 0;
  localparam int unsigned FRAME_ID_BITS = 16;

  typedef logic [TYPE_BITS-1:0] word_type_t;

  localparam word_type_t FRAME_START = 3'd1;
  localparam word_type_t RESULT      = 3'd2;
  localparam word_type_t FRAME_END   = 3'd3;
  localparam word_type_t CHECKSUM    = 3'd4;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StTrailer,
    StChecksum
  } state_e;

  function automatic logic [WORD_BITS-1:0] pack_word(input word_type_t            wtype,
                                                     input logic [PAYLOAD_BITS-1:0] payload);
    logic [WORD_BITS-1:0] w;
    w = '0;
    w[TYPE_LSB +: TYPE_BITS]       = wtype;
    w[PAYLOAD_LSB +: PAYLOAD_BITS] = payload;
    return w;
  endfunction

endpackage

// File: rtl/solver_result_fifo_writer_if.sv
// FPGA-to-HPS FIFO write bus: master is the word producer, slave the Qsys FIFO write slave.
interface solver_result_fifo_writer_if;

  logic        fifo_full;
  logic        fifo_write;
  logic [31:0] fifo_writedata;

  modport master (
    input  fifo_full,
    output fifo_write,
    output fifo_writedata
  );

  modport slave (
    output fifo_full,
    input  fifo_write,
    input  fifo_writedata
  );

endinterface

// File: rtl/fifo_out_stage.sv
// Single-entry holding register in front of the FIFO write slave; frees in the
// same cycle its word is written so the producer can keep 1 word/clock.
module fifo_out_stage #(
  parameter int unsigned WORD_BITS = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WORD_BITS-1:0] word,
  input  logic                 fifo_full,
  output logic                 free,
  output logic                 valid,
  output logic                 fifo_write,
  output logic [WORD_BITS-1:0] fifo_writedata
);

  logic [WORD_BITS-1:0] out_word;

  // load is only asserted by the producer when free is high
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid    <= 1'b0;
      out_word <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      out_word <= word;
    end else if (fifo_write) begin
      valid    <= 1'b0;
    end
  end

  always_comb begin
    fifo_write     = valid && !fifo_full;
    free           = !valid || fifo_write;
    fifo_writedata = out_word;
  end

endmodule

// File: rtl/solver_result_fifo_writer.sv
// Packs solver results into tagged FIFO words framed by FRAME_START / FRAME_END.
// Define SOLVER_FIFO_CHECKSUM_EN to append a CHECKSUM word (XOR of RESULT payloads).
module solver_result_fifo_writer #(
  parameter int unsigned ADDR_BITS = 19,
  parameter int unsigned ITER_BITS = 10,
  parameter int unsigned TYPE_BITS = fractal_fifo_pkg::TYPE_BITS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    frame_start,
  input  logic [15:0]             frame_id,
  input  logic                    frame_end,
  input  logic                    res_valid,
  output logic                    res_ready,
  input  logic [ADDR_BITS-1:0]    res_addr,
  input  logic [ITER_BITS-1:0]    res_iter,
  solver_result_fifo_writer_if.master fifo,
  output logic                    busy,
  output logic                    proto_err
);
  import fractal_fifo_pkg::*;

  if ((TYPE_BITS + ADDR_BITS + ITER_BITS != WORD_BITS) ||
      (TYPE_BITS != fractal_fifo_pkg::TYPE_BITS)) begin : g_width_check
    $error("solver_result_fifo_writer: TYPE_BITS + ADDR_BITS + ITER_BITS must equal 32");
  end

  state_e                   state;
  logic                     pending_end;
  logic [ADDR_BITS-1:0]     count;
  logic                     load;
  logic [WORD_BITS-1:0]     load_word;
  logic                     free;
  logic                     out_valid;
  logic                     accept;
  logic                     end_now;
  logic [PAYLOAD_BITS-1:0]  result_payload;
`ifdef SOLVER_FIFO_CHECKSUM_EN
  logic [PAYLOAD_BITS-1:0]  csum;
`endif

  fifo_out_stage #(
    .WORD_BITS (WORD_BITS)
  ) u_out_stage (
    .clock          (clock),
    .reset          (reset),
    .load           (load),
    .word           (load_word),
    .fifo_full      (fifo.fifo_full),
    .free           (free),
    .valid          (out_valid),
    .fifo_write     (fifo.fifo_write),
    .fifo_writedata (fifo.fifo_writedata)
  );

  always_comb begin
    result_payload = PAYLOAD_BITS'({res_addr, res_iter});
    res_ready      = (state == StStream) && !pending_end && free;
    accept         = res_valid && res_ready;
    // A result offered alongside frame_end wins; the trailer follows next cycle.
    end_now        = (state == StStream) && !accept && (frame_end || pending_end) && free;
    busy           = (state != StIdle) || out_valid;

    load      = 1'b0;
    load_word = '0;
    case (state)
      StIdle: begin
        if (frame_start) begin
          load      = 1'b1;
          load_word = pack_word(FRAME_START, PAYLOAD_BITS'(frame_id));
        end
      end
      StStream: begin
        if (accept) begin
          load      = 1'b1;
          load_word = pack_word(RESULT, result_payload);
        end else if (end_now) begin
          load      = 1'b1;
          load_word = pack_word(FRAME_END, PAYLOAD_BITS'(count));
        end
      end
`ifdef SOLVER_FIFO_CHECKSUM_EN
      StTrailer: begin
        // FRAME_END leaves the register this cycle; chain the checksum behind it
        if (free) begin
          load      = 1'b1;
          load_word = pack_word(CHECKSUM, csum);
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= StIdle;
      pending_end <= 1'b0;
      count       <= '0;
      proto_err   <= 1'b0;
`ifdef SOLVER_FIFO_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      if ((frame_end && state == StIdle) || (frame_start && state != StIdle)) begin
        proto_err <= 1'b1;
      end

      case (state)
        StIdle: begin
          if (frame_start) begin
            count       <= '0;
            pending_end <= 1'b0;
`ifdef SOLVER_FIFO_CHECKSUM_EN
            csum        <= '0;
`endif
            state       <= StStream;
          end
        end
        StStream: begin
          if (accept) begin
            if (count != {ADDR_BITS{1'b1}}) begin
              count <= count + ADDR_BITS'(1);
            end
`ifdef SOLVER_FIFO_CHECKSUM_EN
            csum <= csum ^ result_payload;
`endif
          end
          if (frame_end) begin
            pending_end <= 1'b1;
          end
          if (end_now) begin
            state <= StTrailer;
          end
        end
        StTrailer: begin
          if (fifo.fifo_write) begin
            pending_end <= 1'b0;
`ifdef SOLVER_FIFO_CHECKSUM_EN
            state       <= StChecksum;
`else
            state       <= StIdle;
`endif
          end
        end
`ifdef SOLVER_FIFO_CHECKSUM_EN
        StChecksum: begin
          if (fifo.fifo_write) begin
            state <= StIdle;
          end
        end
`endif
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_solver_result_fifo_writer.sv
// Directed bench for solver_result_fifo_writer with a scoreboard of expected FIFO words.
module tb_solver_result_fifo_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        frame_start = 1'b0;
  logic [15:0] frame_id = '0;
  logic        frame_end = 1'b0;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic [18:0] res_addr = '0;
  logic [9:0]  res_iter = '0;
  logic        busy;
  logic        proto_err;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] exp_q[$];

  solver_result_fifo_writer_if fifo_bus();

  solver_result_fifo_writer dut (
    .clock       (clock),
    .reset       (reset),
    .frame_start (frame_start),
    .frame_id    (frame_id),
    .frame_end   (frame_end),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_addr    (res_addr),
    .res_iter    (res_iter),
    .fifo        (fifo_bus),
    .busy        (busy),
    .proto_err   (proto_err)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] res_word(input int a, input int it);
    logic [18:0] a19;
    logic [9:0]  i10;
    a19 = 19'(a);
    i10 = 10'(it);
    return {3'd2, a19, i10};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs were driven just after the previous edge; sample the write, then advance.
  task automatic step();
    logic [31:0] exp_word;
    #1;
    if (fifo_bus.fifo_write === 1'b1) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_word = exp_q.pop_front();
        check("fifo_word", fifo_bus.fifo_writedata, exp_word);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic open_frame(input logic [15:0] id);
    frame_start = 1'b1;
    frame_id    = id;
    exp_q.push_back({3'd1, 13'd0, id});
    step();
    frame_start = 1'b0;
  endtask

  task automatic offer(input int a, input int it);
    res_valid = 1'b1;
    res_addr  = 19'(a);
    res_iter  = 10'(it);
  endtask

  initial begin
    fifo_bus.fifo_full = 1'b0;

    // Asynchronous reset, checked away from any clock edge
    #2 reset = 1'b1;
    #1;
    check("rst_write", 32'(fifo_bus.fifo_write), 32'd0);
    check("rst_data", fifo_bus.fifo_writedata, 32'd0);
    check("rst_ready", 32'(res_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_perr", 32'(proto_err), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Basic frame, back-to-back results
    open_frame(16'h00A5);
    for (int i = 0; i < 3; i++) begin
      offer(i, 5);
      exp_q.push_back(res_word(i, 5));
      #1;
      check("basic_ready", 32'(res_ready), 32'd1);
      check("basic_nogap", 32'(fifo_bus.fifo_write), 32'd1);
      check("basic_busy", 32'(busy), 32'd1);
      step();
    end
    res_valid = 1'b0;
    frame_end = 1'b1;
    exp_q.push_back(32'h6000_0003);
    step();
    frame_end = 1'b0;
    step();
    step();
    check("basic_idle_busy", 32'(busy), 32'd0);

    // Backpressure: one buffered word, then hold
    open_frame(16'h0011);
    offer(10, 1);
    exp_q.push_back(res_word(10, 1));
    step();
    fifo_bus.fifo_full = 1'b1;
    offer(11, 1);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_ready", 32'(res_ready), 32'd0);
      check("bp_hold", fifo_bus.fifo_writedata, res_word(10, 1));
      check("bp_nowrite", 32'(fifo_bus.fifo_write), 32'd0);
      step();
    end
    fifo_bus.fifo_full = 1'b0;
    exp_q.push_back(res_word(11, 1));
    #1;
    check("bp_resume", 32'(res_ready), 32'd1);
    step();
    offer(12, 1);
    exp_q.push_back(res_word(12, 1));
    step();
    res_valid = 1'b0;
    frame_end = 1'b1;
    exp_q.push_back(32'h6000_0003);
    step();
    frame_end = 1'b0;
    step();
    step();

    // Result and frame_end in the same cycle
    open_frame(16'h0022);
    offer(7, 3);
    frame_end = 1'b1;
    exp_q.push_back(res_word(7, 3));
    exp_q.push_back(32'h6000_0001);
    #1;
    check("sim_ready", 32'(res_ready), 32'd1);
    step();
    res_valid = 1'b0;
    frame_end = 1'b0;
    step();
    step();
    step();
    check("sim_done_busy", 32'(busy), 32'd0);

    // frame_start while streaming is ignored but flagged
    check("pe_clear", 32'(proto_err), 32'd0);
    open_frame(16'h0033);
    offer(4, 9);
    exp_q.push_back(res_word(4, 9));
    step();
    res_valid   = 1'b0;
    frame_start = 1'b1;
    frame_id    = 16'h0044;
    step();
    frame_start = 1'b0;
    check("pe_stream_start", 32'(proto_err), 32'd1);
    frame_end = 1'b1;
    exp_q.push_back(32'h6000_0001);
    step();
    frame_end = 1'b0;
    step();
    step();
    check("pe_sticky", 32'(proto_err), 32'd1);

    // Reset mid-frame with a word stuck behind fifo_full
    open_frame(16'h0055);
    offer(20, 0);
    exp_q.push_back(res_word(20, 0));
    step();
    offer(21, 0);
    exp_q.push_back(res_word(21, 0));
    step();
    res_valid = 1'b0;
    fifo_bus.fifo_full = 1'b1;
    #1;
    check("mid_held", fifo_bus.fifo_writedata, res_word(21, 0));
    #2 reset = 1'b1;
    #1;
    check("mid_rst_write", 32'(fifo_bus.fifo_write), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_data", fifo_bus.fifo_writedata, 32'd0);
    check("mid_rst_perr", 32'(proto_err), 32'd0);
    check("mid_rst_pending", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    fifo_bus.fifo_full = 1'b0;
    open_frame(16'h0066);
    offer(1, 2);
    exp_q.push_back(res_word(1, 2));
    step();
    res_valid = 1'b0;
    frame_end = 1'b1;
    exp_q.push_back(32'h6000_0001);
    step();
    frame_end = 1'b0;
    step();
    step();

    // frame_end in IDLE is ignored but flagged
    check("pe_idle_clear", 32'(proto_err), 32'd0);
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    check("pe_idle_end", 32'(proto_err), 32'd1);
    step();
    check("pe_idle_busy", 32'(busy), 32'd0);

`ifdef SOLVER_FIFO_CHECKSUM_EN
    open_frame(16'h0077);
    offer(0, 1);
    exp_q.push_back(res_word(0, 1));
    step();
    offer(0, 3);
    exp_q.push_back(res_word(0, 3));
    step();
    res_valid = 1'b0;
    frame_end = 1'b1;
    exp_q.push_back(32'h6000_0002);
    exp_q.push_back(32'h8000_0002);
    step();
    frame_end = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("csum_idle_busy", 32'(busy), 32'd0);
`endif

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/solver_result_fifo_writer.md
Name: solver_result_fifo_writer

Overview:
- Packs solver results (pixel address plus iteration count) into 32-bit tagged words and writes them into the FPGA-to-HPS FIFO write port.
- Each frame is framed by a FRAME_START word and a FRAME_END word carrying the result count.
- It is the encoding counterpart of hps_fifo_decoder: the same type-tag word format, in the opposite direction.
- It sits between solver_manager result outputs and the Qsys FIFO write slave.

Parameters:
- ADDR_BITS, 19, pixel address width (640x480 = 307200 fits in 19 bits).
- ITER_BITS, 10, iteration count width.
- TYPE_BITS, 3, word type tag width.
- Constraint: TYPE_BITS + ADDR_BITS + ITER_BITS must equal 32. Elaboration error otherwise.

Ports:
- clock  in  1  single system clock.
- reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse that opens a frame.
- frame_id  in  16  frame tag, sampled with frame_start.
- frame_end  in  1  one-cycle pulse that closes a frame.
- res_valid  in  1  a result is offered.
- res_ready  out  1  the result is accepted when res_valid && res_ready.
- res_addr  in  ADDR_BITS  pixel address of the result.
- res_iter  in  ITER_BITS  iteration count of the result.
- fifo_full  in  1  FIFO write slave is full.
- fifo_write  out  1  write strobe.
- fifo_writedata  out  32  word being written.
- busy  out  1  high whenever the state is not IDLE or a word is pending.
- proto_err  out  1  sticky protocol error flag; cleared only by reset.

Behaviour:
- Word format: [31:29] type, [28:0] payload.
  - FRAME_START = 3'd1, payload = {13'b0, frame_id}.
  - RESULT = 3'd2, payload = {res_addr, res_iter}.
  - FRAME_END = 3'd3, payload = {10'b0, count}.
  - CHECKSUM = 3'd4 (optional feature only).
- Output stage: single-entry holding register (out_valid, out_word).
  - fifo_write = out_valid && !fifo_full, combinational from registered state.
  - fifo_writedata = out_word.
  - The register frees on the same cycle fifo_write is high, so it can be reloaded that cycle.
  - Throughput is 1 word/clock when fifo_full is low.
- States: IDLE, STREAM, TRAILER.
- IDLE:
  - res_ready = 0.
  - On frame_start: load FRAME_START word, clear count, go to STREAM.
  - frame_end in IDLE is ignored and sets proto_err.
- STREAM:
  - res_ready = !pending_end && (!out_valid || fifo_write).
  - An accepted result is loaded as a RESULT word and count is incremented.
  - count is ADDR_BITS wide and saturates at 2^ADDR_BITS-1.
  - frame_end sets pending_end.
  - If res_valid && res_ready and frame_end occur in the same cycle, the result is accepted first and included in count.
  - While pending_end is set and the holding register is free, load FRAME_END with the final count and go to TRAILER.
  - frame_start in STREAM is ignored and sets proto_err.
- TRAILER: wait until the FRAME_END word is written, then go to IDLE and clear pending_end.
- Latency: event or accept at cycle n gives fifo_write at cycle n+1 if fifo_full = 0.
  - If fifo_full stays high, the word holds stable and res_ready drops. No word is ever dropped or duplicated.
- Reset values: state = IDLE, out_valid = 0, fifo_write = 0, fifo_writedata = 0, res_ready = 0, busy = 0, proto_err = 0, count = 0, pending_end = 0.
- Reset mid-frame: the frame is abandoned with no trailer, and any pending word is discarded.

Optional Feature:
- Macro: SOLVER_FIFO_CHECKSUM_EN.
- With the macro:
  - A 29-bit running XOR of all RESULT payloads in the frame is kept, cleared on frame_start.
  - After FRAME_END is written, a CHECKSUM word (type 3'd4, payload = XOR) is written in an extra CHECKSUM state before returning to IDLE.
- Without the macro: no checksum state and no checksum word; FRAME_END returns directly to IDLE.

Decomposition:
- Shared package fractal_fifo_pkg, also used by hps_fifo_decoder, holds:
  - TYPE_BITS and the type codes FRAME_START, RESULT, FRAME_END, CHECKSUM;
  - the payload field offsets;
  - the state enum typedef.
- Sub-module fifo_out_stage: the holding register plus the fifo_full/fifo_write handshake.
  - Inputs: load, word.
  - Outputs: free, fifo_write, fifo_writedata.
- The FSM, counter and checksum stay in the top module.

Test Plan:
- Basic frame: frame_start with frame_id=16'h00A5, fifo_full=0, then 3 results (addr 0/1/2, iter 10'd5), then frame_end. Required FIFO words in order: 32'h200000A5, {3'd2,19'd0,10'd5}, {3'd2,19'd1,10'd5}, {3'd2,19'd2,10'd5}, {3'd3,29'd3}. No gaps with back-to-back res_valid.
- Backpressure: hold fifo_full=1 for 10 cycles during STREAM. Required: fifo_writedata stable, res_ready=0 after one buffered word, no word loss. Word order resumes exactly when fifo_full=0.
- Simultaneous events: frame_end and an accepted result (addr 19'd7) in the same cycle. Required: RESULT addr 7 is written before FRAME_END, and FRAME_END count includes it.
- Protocol errors: frame_start while in STREAM; frame_end while in IDLE. Required: proto_err=1 sticky, no extra words, frame continues normally.
- Reset mid-frame: async reset after 2 results, with fifo_full=1 holding a word. Required: fifo_write=0 and busy=0 immediately. A new frame then starts cleanly with count 0.
- With SOLVER_FIFO_CHECKSUM_EN: results with payloads 29'h1 and 29'h3. Required: after FRAME_END, a CHECKSUM word {3'd4,29'h2} is written.
